smp_wavefront_scheduler: RTL and testbench

//  Sequences pixels of a WIDTH x HEIGHT grid through sequencial_message_passer for TRW-S.

---
 rtl/smp_sched_pkg.sv | 16 +
 rtl/smp_tag_delay.sv | 44 ++++
 rtl/smp_wavefront_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_smp_wavefront_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/smp_sched_pkg.sv
// Shared types and constants for the TRW-S wavefront scheduler.
package smp_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SYNC  = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  localparam int SMP_LAT_DEF = 8;

endpackage

// File: rtl/smp_tag_delay.sv
// Fixed-depth shift register carrying the {valid, addr, dir} tag of each issued
// pixel alongside its trip through the memory and the message passer.
module smp_tag_delay
  import smp_sched_pkg::*;
#(
  parameter int DEPTH = 9,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  input  logic          in_dir,
  output logic          out_vld,
  output logic [AW-1:0] out_addr,
  output logic          out_dir
);

  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1]         dir_pipe;
  logic [DEPTH:1][AW-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      dir_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      dir_pipe[1]  <= in_dir;
      addr_pipe[1] <= in_addr;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        dir_pipe[i]  <= dir_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH];
  assign out_addr = addr_pipe[DEPTH];
  assign out_dir  = dir_pipe[DEPTH];

endmodule

// File: rtl/smp_wavefront_scheduler.sv
// Anti-diagonal forward/backward pixel sequencer feeding the message passer.
// Optional SMP_SCHED_PERF_EN adds issue/stall performance counters.
module smp_wavefront_scheduler
  import smp_sched_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 48,
  parameter int PIX_AW     = 12,
  parameter int ITER_WIDTH = 8,
  parameter int RD_LAT     = 1,
  parameter int SMP_LAT    = SMP_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] iterations,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [PIX_AW-1:0]     rd_addr,
  output logic                  pass_dir,
  output logic                  smp_push,
  input  logic                  smp_valid,
  output logic                  wr_en,
  output logic [PIX_AW-1:0]     wr_addr,
  output logic                  wr_dir,
  output logic                  err
`ifdef SMP_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  localparam int DMAX  = WIDTH + HEIGHT - 2;
  localparam int DW    = $clog2(DMAX + 1);
  localparam int YW    = $clog2(HEIGHT);
  localparam int OW    = $clog2(RD_LAT + SMP_LAT + HEIGHT + 1);
  localparam int DEPTH = RD_LAT + SMP_LAT;
  localparam logic [DW-1:0] DMAX_D = DW'(DMAX);

  sched_state_e          state, state_nxt;
  logic [DW-1:0]         d;
  logic [YW-1:0]         y;
  logic                  dir;
  logic [ITER_WIDTH-1:0] iter, iter_tot;
  logic [OW-1:0]         outstanding, out_nxt;
  logic                  last_pix, last_iter, sync_go, accept, dec;
  logic [RD_LAT:1]       push_pipe;
  logic                  tag_vld, done_q, err_q;
  int                    addr_i;

  function automatic logic [YW-1:0] y_lo(input logic [DW-1:0] dd);
    int v;
    v = int'(dd) - WIDTH + 1;
    if (v < 0) v = 0;
    return YW'(v);
  endfunction

  function automatic logic [YW-1:0] y_hi(input logic [DW-1:0] dd);
    int v;
    v = int'(dd);
    if (v > HEIGHT - 1) v = HEIGHT - 1;
    return YW'(v);
  endfunction

  assign accept    = (state == S_IDLE) && start;
  assign last_pix  = (dir == DIR_FWD) ? (y == y_hi(d)) : (y == y_lo(d));
  assign last_iter = ({1'b0, iter} + 1'b1) == {1'b0, iter_tot};

  // A return in the same cycle as the last wait lets SYNC leave one cycle early.
  assign dec = smp_valid && ((outstanding != '0) || rd_en);
  always_comb begin
    out_nxt = outstanding;
    case ({rd_en, dec})
      2'b10:   out_nxt = outstanding + 1'b1;
      2'b01:   out_nxt = outstanding - 1'b1;
      default: out_nxt = outstanding;
    endcase
  end
  assign sync_go = (state == S_SYNC) && (out_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (iterations != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (last_pix) state_nxt = S_SYNC;
      S_SYNC:  if (sync_go)
                 state_nxt = (dir == DIR_BWD && d == '0 && last_iter) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en = (state == S_ISSUE);
    busy  = (state != S_IDLE);
  end

  always_comb begin
    addr_i  = int'(y) * WIDTH + int'(d) - int'(y);
    rd_addr = rd_en ? PIX_AW'(addr_i) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d        <= '0;
      y        <= '0;
      dir      <= DIR_FWD;
      iter     <= '0;
      iter_tot <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          iter_tot <= iterations;
          iter     <= '0;
          d        <= '0;
          y        <= '0;
          dir      <= DIR_FWD;
        end
        S_ISSUE: if (!last_pix) y <= (dir == DIR_FWD) ? y + 1'b1 : y - 1'b1;
        S_SYNC: if (sync_go) begin
          if (dir == DIR_FWD && d != DMAX_D) begin
            d <= d + 1'b1;
            y <= y_lo(d + 1'b1);
          end else if (dir == DIR_FWD) begin
            dir <= DIR_BWD;
            d   <= DMAX_D;
            y   <= YW'(HEIGHT - 1);
          end else if (d != '0) begin
            d <= d - 1'b1;
            y <= y_hi(d - 1'b1);
          end else begin
            iter <= iter + 1'b1;
            dir  <= DIR_FWD;
            d    <= '0;
            y    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      push_pipe   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      outstanding  <= out_nxt;
      push_pipe[1] <= rd_en;
      for (int i = 2; i <= RD_LAT; i++) push_pipe[i] <= push_pipe[i-1];
      done_q       <= (state == S_DONE);
      err_q        <= err;
    end
  end

  smp_tag_delay #(.DEPTH(DEPTH), .AW(PIX_AW)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_en),
    .in_addr (rd_addr),
    .in_dir  (dir & rd_en),
    .out_vld (tag_vld),
    .out_addr(wr_addr),
    .out_dir (wr_dir)
  );

  assign done     = done_q;
  assign pass_dir = dir;
  assign smp_push = push_pipe[RD_LAT];
  assign wr_en    = smp_valid;
  // Combinational term flags the mismatch in the very cycle it happens.
  assign err      = err_q | (smp_valid != tag_vld);

`ifdef SMP_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (rd_en && !(&perf_issued)) perf_issued <= perf_issued + 1'b1;
      if (state == S_SYNC && outstanding != '0 && !(&perf_stall))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_smp_wavefront_scheduler.sv
// Self-checking bench: 4x3 grid, passer model, queue-based reference ordering.
module tb_smp_wavefront_scheduler;

  localparam int W = 4, H = 3, AW = 4, IW = 8, RD_LAT = 1, SMP_LAT = 8;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW-1:0] iterations;
  logic          busy, done, rd_en, pass_dir, smp_push, smp_valid;
  logic          wr_en, wr_dir, err;
  logic [AW-1:0] rd_addr, wr_addr;
`ifdef SMP_SCHED_PERF_EN
  logic [31:0]   perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  smp_wavefront_scheduler #(
    .WIDTH(W), .HEIGHT(H), .PIX_AW(AW), .ITER_WIDTH(IW), .RD_LAT(RD_LAT), .SMP_LAT(SMP_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .iterations(iterations),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .pass_dir(pass_dir), .smp_push(smp_push), .smp_valid(smp_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_dir(wr_dir), .err(err)
`ifdef SMP_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  // Passer model: fixed latency, optionally swallows one result.
  logic [SMP_LAT-1:0] ppipe;
  logic drop_req, dropped, pipe_out;
  assign pipe_out  = ppipe[SMP_LAT-1];
  assign smp_valid = pipe_out & ~(drop_req & ~dropped);
  always @(posedge clk) begin
    if (rst) ppipe <= '0;
    else     ppipe <= {ppipe[SMP_LAT-2:0], smp_push};
    if (!drop_req)    dropped <= 1'b0;
    else if (pipe_out) dropped <= 1'b1;
  end

  // Monitor: append-only logs, sampled away from the active edge.
  int iss_addr[$], iss_cyc[$], wr_addr_q[$];
  bit iss_dir[$], wr_dir_q[$];
  int done_cnt = 0, cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      iss_addr.push_back(int'(rd_addr));
      iss_dir.push_back(pass_dir);
      iss_cyc.push_back(cyc);
    end
    if (wr_en) begin
      wr_addr_q.push_back(int'(wr_addr));
      wr_dir_q.push_back(wr_dir);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference order: walk every diagonal and keep the in-grid cells.
  task automatic build_model(input int iters, output int ea[$], output bit ed[$]);
    ea.delete(); ed.delete();
    for (int it = 0; it < iters; it++) begin
      for (int dd = 0; dd <= W + H - 2; dd++)
        for (int yy = 0; yy < H; yy++)
          if (dd - yy >= 0 && dd - yy < W) begin ea.push_back(yy * W + dd - yy); ed.push_back(1'b0); end
      for (int dd = W + H - 2; dd >= 0; dd--)
        for (int yy = H - 1; yy >= 0; yy--)
          if (dd - yy >= 0 && dd - yy < W) begin ea.push_back(yy * W + dd - yy); ed.push_back(1'b1); end
    end
  endtask

  task automatic run_iters(input int iters, input bit noise, output int base, output int n_iss);
    int bw, bd, bad, got_done;
    int ea[$];
    bit ed[$];
    build_model(iters, ea, ed);
    base = iss_addr.size(); bw = wr_addr_q.size(); bd = done_cnt; got_done = 0;
    @(negedge clk); start = 1'b1; iterations = IW'(iters);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1; start = 1'b0; break; end
      if (noise && $urandom_range(0, 7) == 0) begin
        start = 1'b1; iterations = IW'($urandom);
      end else start = 1'b0;
    end
    start = 1'b0;
    check("done_reached", got_done, 1);
    @(negedge clk);
    n_iss = iss_addr.size() - base;
    check("issue_count", n_iss, ea.size());
    bad = 0;
    foreach (ea[k])
      if (base + k >= iss_addr.size() || iss_addr[base+k] != ea[k] || iss_dir[base+k] != ed[k]) bad++;
    check("issue_order_errs", bad, 0);
    bad = 0;
    foreach (ea[k])
      if (bw + k >= wr_addr_q.size() || wr_addr_q[bw+k] != ea[k] || wr_dir_q[bw+k] != ed[k]) bad++;
    check("wb_order_errs", bad, 0);
    check("wb_count", wr_addr_q.size() - bw, ea.size());
    check("done_pulses", done_cnt - bd, 1);
    check("err_clear", int'(err), 0);
    check("busy_after", int'(busy), 0);
`ifdef SMP_SCHED_PERF_EN
    check("perf_issued", int'(perf_issued), ea.size());
    check("perf_stall_nz", int'(perf_stall != 0), 1);
`endif
  endtask

  function automatic int out_bits();
    return int'({busy, done, rd_en, rd_addr, pass_dir, smp_push, wr_en, wr_addr, wr_dir, err});
  endfunction

  typedef struct { int iters; bit noise; int exp_issued; } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int lit[24];
    int base, n, hit, any_rd, any_done, seen;
    vecs[0] = '{1, 1'b0, 24};
    vecs[1] = '{2, 1'b0, 48};
    vecs[2] = '{3, 1'b0, 72};
    vecs[3] = '{1, 1'b1, 24};
    lit = '{0,1,4,2,5,8,3,6,9,7,10,11, 11,10,7,9,6,3,8,5,2,4,1,0};

    rst = 1'b1; start = 1'b0; iterations = '0; drop_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", out_bits(), 0);
    rst = 1'b0;
    @(negedge clk);

    // Known 4x3 sequence and diagonal-to-diagonal latency.
    run_iters(1, 1'b0, base, n);
    for (int k = 0; k < 24; k++)
      if (base + k < iss_addr.size()) check("literal_seq", iss_addr[base+k], lit[k]);
    if (base + 1 < iss_cyc.size())
      check("diag1_gap", iss_cyc[base+1] - iss_cyc[base], RD_LAT + SMP_LAT + 1);
    else check("diag1_gap_present", 0, 1);

    // Zero iterations: one busy cycle, done two cycles after start.
    base = iss_addr.size();
    @(negedge clk); start = 1'b1; iterations = '0;
    @(negedge clk); start = 1'b0;
    check("it0_busy1", int'({busy, done}), 2);
    @(negedge clk);
    check("it0_done", int'({busy, done}), 1);
    @(negedge clk);
    check("it0_done_low", int'(done), 0);
    check("it0_no_rd", iss_addr.size() - base, 0);

    // Reset in the middle of the backward pass.
    @(negedge clk); start = 1'b1; iterations = 8'd1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rd_en && pass_dir) begin seen = 1; break; end
    end
    check("reached_bwd", seen, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", out_bits(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", int'(busy), 0);
    run_iters(1, 1'b0, base, n);
    if (base < iss_addr.size()) check("replay_first_addr", iss_addr[base], 0);

    // Dropped result: err in the drop cycle, sticky, FSM parked in SYNC.
    drop_req = 1'b1;
    @(negedge clk); start = 1'b1; iterations = 8'd1;
    @(negedge clk); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pipe_out && !smp_valid) begin hit = 1; check("err_on_drop", int'(err), 1); break; end
    end
    check("drop_seen", hit, 1);
    any_rd = 0; any_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (rd_en) any_rd = 1;
      if (done) any_done = 1;
    end
    check("err_sticky", int'(err), 1);
    check("stall_busy", int'(busy), 1);
    check("stall_no_rd", any_rd, 0);
    check("stall_no_done", any_done, 0);
    rst = 1'b1; drop_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("err_cleared_by_rst", int'(err), 0);

    // Table of runs.
    for (int v = 0; v < 4; v++) begin
      run_iters(vecs[v].iters, vecs[v].noise, base, n);
      check("tbl_issued", n, vecs[v].exp_issued);
    end

    // Randomised runs with random idle gaps and ignored starts.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_iters(int'($urandom_range(1, 3)), 1'(($urandom_range(0, 1))), base, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
